// File: rtl/uart_alu_pkg.sv
// Shared constants, FSM state types and packet layout for the UART ALU host.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;
  localparam logic [7:0] OP_DIV  = 8'hD1;

  localparam logic [7:0]  HDR_RSVD   = 8'h00;
  localparam int unsigned PKT_LEN    = 12;
  localparam int unsigned RSP_LEN    = 4;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RECV, ST_RESP} host_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Packet: opcode, reserved, length, reserved, A little-endian, B little-endian.
  function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic [7:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [7:0] r;
    case (idx)
      4'd0:    r = op;
      4'd1:    r = HDR_RSVD;
      4'd2:    r = 8'(PKT_LEN);
      4'd3:    r = HDR_RSVD;
      4'd4:    r = a[7:0];
      4'd5:    r = a[15:8];
      4'd6:    r = a[23:16];
      4'd7:    r = a[31:24];
      4'd8:    r = b[7:0];
      4'd9:    r = b[15:8];
      4'd10:   r = b[23:16];
      4'd11:   r = b[31:24];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_alu_host_rx.sv
// Free-running 8N1 receiver: synchroniser, start-bit validation, mid-bit sampling, framing check.
module uart_host_rx
  import uart_alu_pkg::*;
#(
  parameter int unsigned CPB = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o
);

  localparam int unsigned CW = $clog2(CPB);

  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q;
  logic        prev_q;
  logic        rx_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        vld_q, vld_d;
  logic [7:0]  data_q, data_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    vld_d   = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = RX_START;
      end
      // Line back high at the start-bit centre means a glitch: re-arm.
      RX_START: if (cnt_q == CW'(CPB / 2 - 1)) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d = '0;
        sh_d  = {rx_s, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d   = '0;
        state_d = RX_IDLE;
        if (rx_s) begin
          vld_d  = 1'b1;
          data_d = sh_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign byte_valid_o = vld_q;
  assign byte_data_o  = data_q;

endmodule

// File: rtl/uart_alu_host.sv
// UART ALU host: sends one 12-byte command packet on tx_o, collects a 4-byte result from rx_i.
module uart_alu_host
  import uart_alu_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned TIMEOUT_BITS = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_opcode_i,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_timeout_o,
  output logic        busy_o,
  output logic        tx_o,
  input  logic        rx_i
);

  localparam int unsigned CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned TMO = TIMEOUT_BITS * CPB;
  localparam int unsigned CW  = $clog2(CPB);
  localparam int unsigned TW  = $clog2(TMO + 1);
  localparam int unsigned BW  = $clog2(PKT_LEN);
  localparam int unsigned RW  = $clog2(RSP_LEN + 1);

  host_state_e   state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [31:0]   data_q, data_d;
  logic          tmof_q, tmof_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic       rx_vld;
  logic [7:0] rx_byte, tx_byte;
  logic       baud_end, send_done, tmo_hit;

  uart_host_rx #(.CPB(CPB)) u_rx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .byte_valid_o (rx_vld),
    .byte_data_o  (rx_byte)
  );

  assign baud_end  = baud_q == CW'(CPB - 1);
  assign send_done = baud_end && bit_q == 4'(FRAME_BITS - 1) && byte_q == BW'(PKT_LEN - 1);
  // A byte landing on the expiry cycle takes priority over the timeout.
  assign tmo_hit   = !rx_vld && tmo_q >= TW'(TMO - 1);
  assign tx_byte   = pkt_byte(4'(byte_q), op_q, a_q, b_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid_i) state_d = ST_SEND;
      ST_SEND: if (send_done) state_d = ST_RECV;
      ST_RECV: if ((rx_vld && rcnt_q == RW'(RSP_LEN - 1)) || tmo_hit) state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = state_q == ST_IDLE;
    busy_o      = state_q != ST_IDLE;
    rsp_valid_o = state_q == ST_RESP;
    tx_o        = 1'b1;
    if (state_q == ST_SEND) begin
      case (bit_q)
        4'd0:                  tx_o = 1'b0;
        4'(FRAME_BITS - 1):    tx_o = 1'b1;
        default:               tx_o = tx_byte[3'(bit_q - 4'd1)];
      endcase
    end
  end

  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    baud_d = baud_q;
    bit_d  = bit_q;
    byte_d = byte_q;
    rcnt_d = rcnt_q;
    data_d = data_q;
    tmof_d = tmof_q;
    tmo_d  = tmo_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid_i) begin
        op_d   = cmd_opcode_i;
        a_d    = cmd_a_i;
        b_d    = cmd_b_i;
        baud_d = '0;
        bit_d  = '0;
        byte_d = '0;
      end
      ST_SEND: begin
        baud_d = baud_end ? '0 : baud_q + 1'b1;
        if (baud_end) begin
          if (bit_q == 4'(FRAME_BITS - 1)) begin
            bit_d  = '0;
            byte_d = byte_q + 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        if (send_done) begin
          rcnt_d = '0;
          tmo_d  = '0;
          data_d = '0;
          tmof_d = 1'b0;
        end
      end
      ST_RECV: begin
        if (rx_vld) begin
          for (int unsigned k = 0; k < RSP_LEN; k++)
            if (rcnt_q == RW'(k)) data_d[8*k +: 8] = rx_byte;
          rcnt_d = rcnt_q + 1'b1;
          tmo_d  = '0;
        end else if (tmo_hit) begin
          data_d = '0;
          tmof_d = 1'b1;
        end else if (tmo_q != TW'(TMO)) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RESP: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      baud_q <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      rcnt_q <= '0;
      data_q <= '0;
      tmof_q <= 1'b0;
      tmo_q  <= '0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
      rcnt_q <= rcnt_d;
      data_q <= data_d;
      tmof_q <= tmof_d;
      tmo_q  <= tmo_d;
    end
  end

  assign rsp_data_o    = data_q;
  assign rsp_timeout_o = tmof_q;

endmodule

// File: tb/tb_uart_alu_host.sv
// Scenario bench for uart_alu_host at CPB=10 with a behavioural UART responder and response scoreboard.
module tb_uart_alu_host;
  import uart_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_tmo;
  logic        busy;
  logic        tx;
  logic        rx = 1'b1;

  always #5 clk = ~clk;

  uart_alu_host #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .TIMEOUT_BITS(64)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_opcode_i  (cmd_op),
    .cmd_a_i       (cmd_a),
    .cmd_b_i       (cmd_b),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .rsp_timeout_o (rsp_tmo),
    .busy_o        (busy),
    .tx_o          (tx),
    .rx_i          (rx)
  );

  typedef struct packed { logic [31:0] data; logic tmo; } rsp_t;
  rsp_t sb[$];

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [119:0] frame;

  task automatic tick();
    @(negedge clk);
    n++;
  endtask

  task automatic start_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
  endtask

  task automatic capture_tx();
    repeat (5) tick();
    for (int k = 0; k < 120; k++) begin
      frame[k] = tx;
      if (k < 119) repeat (10) tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) tick();
    end
    rx = stop;
    repeat (10) tick();
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rsp_valid) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string name);
    bit ok;
    rsp_t got, exp;
    wait_rsp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: rsp_valid got 0 within 3000 cycles, want 1", name);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected response %h, scoreboard empty", name, rsp_data);
    end else begin
      exp = sb.pop_front();
      got = '{data: rsp_data, tmo: rsp_tmo};
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: data/tmo got %h/%b want %h/%b", name, got.data, got.tmo, exp.data, exp.tmo);
      end
    end
  endtask

  task automatic wait_recv();
    while (n < 1205) tick();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({tx, cmd_ready, rsp_valid, rsp_data, rsp_tmo, busy} !== {1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: tx/rdy/vld/data/tmo/busy got %b%b%b %h %b%b want 110 00000000 00",
               tx, cmd_ready, rsp_valid, rsp_data, rsp_tmo, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [7:0] exp_tx [12];
    logic [7:0] got_b;
    exp_tx = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    start_cmd(OP_ADD, 32'd5, 32'd7);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL add_start: tx/busy got %b/%b want 0/1", tx, busy);
    end
    capture_tx();
    for (int b = 0; b < 12; b++) begin
      got_b = frame[b*10+1 +: 8];
      checks++;
      if (frame[b*10] !== 1'b0 || frame[b*10+9] !== 1'b1 || got_b !== exp_tx[b]) begin
        errors++;
        $display("FAIL add_tx_byte%0d: start/data/stop got %b/%h/%b want 0/%h/1",
                 b, frame[b*10], got_b, frame[b*10+9], exp_tx[b]);
      end
    end
    wait_recv();
    sb.push_back('{data: 32'h0000000C, tmo: 1'b0});
    send_word(32'h0000000C);
    check_rsp("add_rsp");
    consume();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_ready_after: cmd_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    start_cmd(OP_MUL, 32'd3, 32'd4);
    sb.push_back('{data: 32'h0, tmo: 1'b1});
    while (n < 1840) begin
      if (rsp_valid) early = 1'b1;
      tick();
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL tmo_early: rsp_valid got 1 before cycle 1840 want 0");
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL tmo_exact: rsp_valid at cycle 1840 got %b want 1", rsp_valid);
    end
    check_rsp("tmo_rsp");
    consume();
  endtask

  task automatic test_framing();
    start_cmd(OP_DIV, 32'd100, 32'd5);
    wait_recv();
    send_byte(8'hFF, 1'b0);
    repeat (10) tick();
    sb.push_back('{data: 32'h12345678, tmo: 1'b0});
    send_word(32'h12345678);
    check_rsp("framing_rsp");
    consume();
  endtask

  task automatic test_glitch();
    start_cmd(OP_ECHO, 32'hDEADBEEF, 32'h0);
    wait_recv();
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (20) tick();
    sb.push_back('{data: 32'hDEADBEEF, tmo: 1'b0});
    send_word(32'hDEADBEEF);
    check_rsp("glitch_rsp");
    consume();
  endtask

  task automatic test_backpressure();
    bit bad = 1'b0;
    start_cmd(OP_ADD, 32'h10, 32'h20);
    wait_recv();
    sb.push_back('{data: 32'h00000030, tmo: 1'b0});
    send_word(32'h00000030);
    check_rsp("bp_rsp");
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h30 || cmd_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: vld/data/rdy got %b/%h/%b want 1/00000030/0", rsp_valid, rsp_data, cmd_ready);
    end
    consume();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rdy/vld got %b/%b want 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_send();
    start_cmd(OP_ADD, 32'd1, 32'd2);
    while (n < 350) tick();
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: tx in byte 3 got %b want 0", tx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_now: tx/vld/busy got %b/%b/%b want 1/0/0", tx, rsp_valid, busy);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: cmd_ready got %b want 1", cmd_ready);
    end
    start_cmd(OP_ADD, 32'd5, 32'd7);
    wait_recv();
    sb.push_back('{data: 32'h0000000C, tmo: 1'b0});
    send_word(32'h0000000C);
    check_rsp("rst_fresh_rsp");
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_timeout();
    test_framing();
    test_glitch();
    test_backpressure();
    test_reset_mid_send();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_alu_host.md
Name: uart_alu_host

Overview:
- Host-side initiator for the board's UART ALU protocol; the other end of the link from the FPGA responder.
- Accepts one ALU command on a valid/ready interface, serialises it as a packet on tx_o (8N1), then deserialises the 4-byte result from rx_i.
- Returns the result, or a timeout flag, on a valid/ready response interface.
- Used as a synthesizable loopback host and as the stimulus/checker engine in board-level benches.

Parameters:
- CLK_FREQ_HZ, 50000000, core clock frequency.
- BAUD_RATE, 115200, UART bit rate. CPB = CLK_FREQ_HZ/BAUD_RATE, integer division, must be >= 4.
- TIMEOUT_BITS, 64, idle bit-periods allowed in RECV before a byte arrives.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command offered.
- cmd_ready_o  output  1  host idle, can accept a command.
- cmd_opcode_i  input  8  ALU opcode.
- cmd_a_i  input  32  operand A.
- cmd_b_i  input  32  operand B.
- rsp_valid_o  output  1  response held.
- rsp_ready_i  input  1  response consumed.
- rsp_data_o  output  32  result, little-endian assembled.
- rsp_timeout_o  output  1  response ended by timeout.
- busy_o  output  1  state != IDLE.
- tx_o  output  1  UART line to responder.
- rx_i  input  1  UART line from responder, asynchronous.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: tx_o=1, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_timeout_o=0, busy_o=0, FSM=IDLE, all counters 0.
- Reset mid-operation aborts immediately, and tx_o returns high in the same instant.
- FSM states: IDLE, SEND, RECV, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i&cmd_ready_o, latch opcode, A and B, then go to SEND.
  - The start bit of byte 0 drives tx_o on the next cycle.
- SEND:
  - Transmits 12 bytes in order: opcode, 0x00, 0x0C, 0x00, A[7:0]..A[31:24], B[7:0]..B[31:24].
  - Each byte is start(0), 8 data bits LSB first, stop(1). Each bit lasts exactly CPB cycles.
  - Bytes are back-to-back with no idle gap: total 120*CPB cycles.
  - After the last stop bit completes, go to RECV with the byte count at 0 and the timeout counter cleared.
- RX path (always running):
  - 2-flop synchroniser on rx_i.
  - A falling edge arms the receiver. Re-sample at CPB/2; if the line is high, treat it as a glitch and re-arm.
  - Data bits are sampled every CPB cycles thereafter; the stop bit is sampled at its centre.
  - Stop bit = 0 is a framing error: discard the byte.
  - Bytes completing outside RECV are discarded.
- RECV:
  - Each good byte shifts into the result: byte k goes to bits 8k+7:8k, and the timeout counter clears.
  - After the 4th good byte, go to RESP on the next cycle with rsp_timeout_o=0.
  - If the timeout counter reaches TIMEOUT_BITS*CPB cycles with no good byte, go to RESP with rsp_timeout_o=1 and rsp_data_o=0.
  - A partial result is discarded on timeout.
  - A byte completing on the same cycle the timeout expires counts as received; the byte wins.
- RESP:
  - rsp_valid_o=1. rsp_data_o and rsp_timeout_o are stable until rsp_valid_o&rsp_ready_i.
  - On that handshake, go to IDLE; cmd_ready_o=1 on the following cycle.
  - Command and response do not overlap.
- Wrap-around:
  - Bit and byte counters are sized by $clog2 and never wrap in legal operation.
  - The timeout counter saturates.

Decomposition:
- Package uart_alu_pkg:
  - opcode constants ECHO=0xEC, ADD=0xAD, MUL=0x88, DIV=0xD1.
  - header reserved byte 0x00, packet length 12.
  - state enum for the FSM.
- Sub-module uart_host_rx: synchroniser, start validation, mid-bit sampling, framing check.
  - Outputs byte_valid pulse and byte_data.
  - Parameter CPB.
- The TX serialiser and the FSM live in uart_alu_host.

Test Plan:
- Common setup: CLK_FREQ_HZ=1000000, BAUD_RATE=100000, so CPB=10.
- ADD: opcode 0xAD, A=5, B=7.
  - tx_o carries AD 00 0C 00 05 00 00 00 07 00 00 00 over exactly 1200 cycles.
  - Model replies 0C 00 00 00 → rsp_data_o=0x0000000C, rsp_timeout_o=0.
- Timeout: MUL command, no reply → rsp_valid_o=1, rsp_timeout_o=1, rsp_data_o=0 exactly 640 cycles after the last stop bit ends.
- Framing: reply byte 0xFF with stop=0 is discarded. Then 78 56 34 12 → rsp_data_o=0x12345678.
- Glitch: 3-cycle low pulse on rx_i in RECV → no byte counted. A subsequent valid 4-byte reply is assembled correctly.
- Backpressure: hold rsp_ready_i=0 for 100 cycles in RESP.
  - rsp_valid_o stays 1, data stays stable, cmd_ready_o stays 0.
  - Raising rsp_ready_i gives cmd_ready_o=1 the next cycle.
- Reset mid-SEND: pull rst_ni low during byte 3.
  - tx_o=1 and rsp_valid_o=0 immediately.
  - After release, cmd_ready_o=1 and a fresh ADD completes normally.
